// File: rtl/bus_master_arbiter_pkg.sv
// Shared types and helpers for the system-bus master arbiter.
package bus_master_arbiter_pkg;

  // Transaction FSM: arbitrate, hold slave bus until ready/timeout, pulse response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned WE_W   = 4;
  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;

  // Width of a master index; a single master still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_master_arbiter_rr_priority_pick.sv
// Combinational winner selection: fixed (lowest index) or round robin after a pointer.
module rr_priority_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          rr_mode_i,
  output logic [N-1:0]  win_oh_o,
  output logic [IW-1:0] win_idx_o,
  output logic          valid_o
);

  int unsigned cand;

  // Scan candidates in priority order; the first requesting one wins.
  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    valid_o   = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // Round robin starts one past the last winner and wraps.
      cand = rr_mode_i ? ((32'(ptr_i) + k + 1) % N) : k;
      for (int unsigned i = 0; i < N; i++) begin
        if (!valid_o && (cand == i) && req_i[i]) begin
          valid_o     = 1'b1;
          win_oh_o[i] = 1'b1;
          win_idx_o   = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// N-master to single-slave system bus arbiter with registered slave bus and timeout.
module bus_master_arbiter
  import bus_master_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                      clk,
  input  logic                      RSTN,
  input  logic [N_MASTERS*AW-1:0]   m_addr,
  input  logic [N_MASTERS*DW-1:0]   m_wdata,
  input  logic [N_MASTERS-1:0]      m_rd,
  input  logic [N_MASTERS*DW/8-1:0] m_we,
  output logic [DW-1:0]             m_rdata,
  output logic [N_MASTERS-1:0]      m_ready,
  output logic [N_MASTERS-1:0]      m_err,
  output logic [N_MASTERS-1:0]      grant,
  output logic                      busy,
  output logic [AW-1:0]             s_addr,
  output logic [DW-1:0]             s_wdata,
  output logic                      s_rd,
  output logic [DW/8-1:0]           s_we,
  input  logic [DW-1:0]             s_rdata,
  input  logic                      s_ready
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned IW = idx_width(N_MASTERS);
  localparam int unsigned CW = $clog2(TIMEOUT);

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   err_q;
  logic [IW-1:0]          ptr_q;
  logic [N_MASTERS-1:0]   grant_q;
  logic [N_MASTERS-1:0]   m_ready_q;
  logic [DW-1:0]          rdata_q;
  logic [AW-1:0]          s_addr_q;
  logic [DW-1:0]          s_wdata_q;
  logic                   s_rd_q;
  logic [BW-1:0]          s_we_q;

  logic [N_MASTERS-1:0]   req;
  logic [N_MASTERS-1:0]   win_oh;
  logic [IW-1:0]          win_idx;
  logic                   win_valid;
  logic [AW-1:0]          sel_addr;
  logic [DW-1:0]          sel_wdata;
  logic [BW-1:0]          sel_we;
  logic                   sel_rd;

  // A master requests when it reads or asserts any byte enable.
  always_comb begin
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      req[i] = m_rd[i] | (|m_we[i*BW +: BW]);
    end
  end

  rr_priority_pick #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .rr_mode_i (PRIO_MODE != 0),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .valid_o   (win_valid)
  );

  // Mux the winning master's request fields; a write suppresses the read strobe.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = '0;
    sel_rd    = 1'b0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (win_oh[i]) begin
        sel_addr  = m_addr[i*AW +: AW];
        sel_wdata = m_wdata[i*DW +: DW];
        sel_we    = m_we[i*BW +: BW];
        sel_rd    = m_rd[i];
      end
    end
    sel_rd = sel_rd & ~(|sel_we);
  end

  // Transaction FSM with all slave-bus and response outputs held in registers.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ptr_q     <= IW'(N_MASTERS - 1);
      grant_q   <= '0;
      m_ready_q <= '0;
      rdata_q   <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_rd_q    <= 1'b0;
      s_we_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            state_q   <= ST_BUSY;
            grant_q   <= win_oh;
            s_addr_q  <= sel_addr;
            s_wdata_q <= sel_wdata;
            s_we_q    <= sel_we;
            s_rd_q    <= sel_rd;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            if (PRIO_MODE != 0) ptr_q <= win_idx;
          end
        end
        ST_BUSY: begin
          if (s_ready) begin
            // Ready beats a simultaneous timeout.
            state_q   <= ST_RESP;
            rdata_q   <= s_rd_q ? s_rdata : '0;
            err_q     <= 1'b0;
            m_ready_q <= grant_q;
            s_rd_q    <= 1'b0;
            s_we_q    <= '0;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q   <= ST_RESP;
            rdata_q   <= '0;
            err_q     <= 1'b1;
            m_ready_q <= grant_q;
            s_rd_q    <= 1'b0;
            s_we_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          state_q   <= ST_IDLE;
          m_ready_q <= '0;
          grant_q   <= '0;
          cnt_q     <= '0;
          err_q     <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_rdata = rdata_q;
  assign m_ready = m_ready_q;
  assign m_err   = m_ready_q & {N_MASTERS{err_q}};
  assign grant   = grant_q;
  assign busy    = (state_q != ST_IDLE);
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_rd    = s_rd_q;
  assign s_we    = s_we_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench: a fixed-priority and a round-robin arbiter share the same stimulus.
module tb_bus_master_arbiter;

  logic        clk = 1'b0;
  logic        RSTN;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [1:0]  m_rd;
  logic [7:0]  m_we;
  logic [31:0] s_rdata;
  logic        s_ready;

  logic [31:0] m_rdata_f, m_rdata_r, s_addr_f, s_addr_r, s_wdata_f, s_wdata_r;
  logic [1:0]  m_ready_f, m_ready_r, m_err_f, m_err_r, grant_f, grant_r;
  logic        busy_f, busy_r, s_rd_f, s_rd_r;
  logic [3:0]  s_we_f, s_we_r;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_master_arbiter #(.N_MASTERS(2), .AW(32), .DW(32), .PRIO_MODE(0), .TIMEOUT(16)) dut_f (
    .clk(clk), .RSTN(RSTN), .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_we(m_we),
    .m_rdata(m_rdata_f), .m_ready(m_ready_f), .m_err(m_err_f), .grant(grant_f), .busy(busy_f),
    .s_addr(s_addr_f), .s_wdata(s_wdata_f), .s_rd(s_rd_f), .s_we(s_we_f),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  bus_master_arbiter #(.N_MASTERS(2), .AW(32), .DW(32), .PRIO_MODE(1), .TIMEOUT(16)) dut_r (
    .clk(clk), .RSTN(RSTN), .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_we(m_we),
    .m_rdata(m_rdata_r), .m_ready(m_ready_r), .m_err(m_err_r), .grant(grant_r), .busy(busy_r),
    .s_addr(s_addr_r), .s_wdata(s_wdata_r), .s_rd(s_rd_r), .s_we(s_we_r),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  typedef struct {
    logic [1:0]  rd;
    logic [7:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] srdata;
    logic [1:0]  exp_g;
    logic        exp_srd;
    logic [3:0]  exp_swe;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer with requests already driven; gf/gr are the expected grants.
  task automatic do_txn(input string nm, input logic [1:0] gf, input logic [1:0] gr,
                        input logic srd, input logic [3:0] swe, input logic [31:0] addr,
                        input logic [31:0] wd, input int waits, input logic [31:0] srdata,
                        input logic [31:0] erd, input logic [1:0] rel);
    step();
    chk($sformatf("%s.grant_f", nm), 64'(grant_f), 64'(gf));
    chk($sformatf("%s.grant_r", nm), 64'(grant_r), 64'(gr));
    chk($sformatf("%s.busy_r", nm), 64'(busy_r), 64'd1);
    chk($sformatf("%s.s_rd_r", nm), 64'(s_rd_r), 64'(srd));
    chk($sformatf("%s.s_rd_f", nm), 64'(s_rd_f), 64'(srd));
    chk($sformatf("%s.s_we_r", nm), 64'(s_we_r), 64'(swe));
    chk($sformatf("%s.s_we_f", nm), 64'(s_we_f), 64'(swe));
    chk($sformatf("%s.s_addr_r", nm), 64'(s_addr_r), 64'(addr));
    chk($sformatf("%s.s_wdata_r", nm), 64'(s_wdata_r), 64'(wd));
    if (gf == gr) chk($sformatf("%s.s_addr_f", nm), 64'(s_addr_f), 64'(addr));
    s_ready = 1'b0;
    for (int w = 0; w < waits; w++) begin
      step();
      chk($sformatf("%s.wait%0d.s_addr_r", nm, w), 64'(s_addr_r), 64'(addr));
      chk($sformatf("%s.wait%0d.s_we_r", nm, w), 64'(s_we_r), 64'(swe));
      chk($sformatf("%s.wait%0d.m_ready_r", nm, w), 64'(m_ready_r), 64'd0);
    end
    s_rdata = srdata;
    s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    s_rdata = 32'hBAD0_BAD0;
    chk($sformatf("%s.m_ready_f", nm), 64'(m_ready_f), 64'(gf));
    chk($sformatf("%s.m_ready_r", nm), 64'(m_ready_r), 64'(gr));
    chk($sformatf("%s.m_err_f", nm), 64'(m_err_f), 64'd0);
    chk($sformatf("%s.m_err_r", nm), 64'(m_err_r), 64'd0);
    chk($sformatf("%s.m_rdata_r", nm), 64'(m_rdata_r), 64'(erd));
    chk($sformatf("%s.m_rdata_f", nm), 64'(m_rdata_f), 64'(erd));
    chk($sformatf("%s.resp_s_rd_r", nm), 64'(s_rd_r), 64'd0);
    chk($sformatf("%s.resp_s_we_r", nm), 64'(s_we_r), 64'd0);
    for (int i = 0; i < 2; i++) begin
      if (rel[i]) begin
        m_rd[i]        = 1'b0;
        m_we[i*4 +: 4] = 4'h0;
      end
    end
    step();
    chk($sformatf("%s.idle_m_ready_r", nm), 64'(m_ready_r), 64'd0);
    chk($sformatf("%s.idle_busy_r", nm), 64'(busy_r), 64'd0);
    chk($sformatf("%s.idle_grant_r", nm), 64'(grant_r), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{rd: 2'b01, we: 8'h00, addr: 32'h0000_2000, wdata: 32'h0, waits: 0,
                srdata: 32'hDEAD_BEEF, exp_g: 2'b01, exp_srd: 1'b1, exp_swe: 4'h0,
                exp_rdata: 32'hDEAD_BEEF};
    vecs[1] = '{rd: 2'b00, we: 8'hF0, addr: 32'h0000_3000, wdata: 32'h1122_3344, waits: 0,
                srdata: 32'h9999_9999, exp_g: 2'b10, exp_srd: 1'b0, exp_swe: 4'hF,
                exp_rdata: 32'h0};
    vecs[2] = '{rd: 2'b00, we: 8'h02, addr: 32'h0000_0044, wdata: 32'hAABB_CCDD, waits: 3,
                srdata: 32'h1234_5678, exp_g: 2'b01, exp_srd: 1'b0, exp_swe: 4'h2,
                exp_rdata: 32'h0};
    vecs[3] = '{rd: 2'b10, we: 8'h00, addr: 32'h0001_0004, wdata: 32'h0, waits: 2,
                srdata: 32'hCAFE_F00D, exp_g: 2'b10, exp_srd: 1'b1, exp_swe: 4'h0,
                exp_rdata: 32'hCAFE_F00D};
    vecs[4] = '{rd: 2'b01, we: 8'h0F, addr: 32'h0000_0008, wdata: 32'h5A5A_5A5A, waits: 1,
                srdata: 32'h5555_5555, exp_g: 2'b01, exp_srd: 1'b0, exp_swe: 4'hF,
                exp_rdata: 32'h0};

    RSTN    = 1'b1;
    m_addr  = '0;
    m_wdata = '0;
    m_rd    = '0;
    m_we    = '0;
    s_rdata = '0;
    s_ready = 1'b0;
    #1 RSTN = 1'b0;
    #1;
    chk("reset.busy_f", 64'(busy_f), 64'd0);
    chk("reset.busy_r", 64'(busy_r), 64'd0);
    chk("reset.grant_r", 64'(grant_r), 64'd0);
    chk("reset.m_ready_r", 64'(m_ready_r), 64'd0);
    chk("reset.s_rd_r", 64'(s_rd_r), 64'd0);
    chk("reset.m_rdata_r", 64'(m_rdata_r), 64'd0);
    repeat (2) @(negedge clk);
    RSTN = 1'b1;

    // Slave ready with nobody on the bus must not produce a response.
    s_ready = 1'b1;
    step();
    step();
    chk("stray_ready.m_ready_r", 64'(m_ready_r), 64'd0);
    chk("stray_ready.busy_r", 64'(busy_r), 64'd0);
    s_ready = 1'b0;

    // Both masters request in the same cycle: master 0 first in either mode, then master 1.
    m_addr  = {32'h0000_3000, 32'h0000_2000};
    m_wdata = {32'h0BAD_F00D, 32'h0};
    m_rd    = 2'b01;
    m_we    = 8'hF0;
    do_txn("simul0", 2'b01, 2'b01, 1'b1, 4'h0, 32'h0000_2000, 32'h0, 0,
           32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b01);
    do_txn("simul1", 2'b10, 2'b10, 1'b0, 4'hF, 32'h0000_3000, 32'h0BAD_F00D, 0,
           32'h1111_1111, 32'h0, 2'b10);

    // Single-master vectors; the other slot carries junk to expose a wrong mux.
    for (int v = 0; v < 5; v++) begin
      m_addr  = {32'hFFFF_0000, 32'hFFFF_0000};
      m_wdata = {32'hEEEE_EEEE, 32'hEEEE_EEEE};
      if (vecs[v].exp_g[0]) begin
        m_addr[31:0]  = vecs[v].addr;
        m_wdata[31:0] = vecs[v].wdata;
      end else begin
        m_addr[63:32]  = vecs[v].addr;
        m_wdata[63:32] = vecs[v].wdata;
      end
      m_rd = vecs[v].rd;
      m_we = vecs[v].we;
      do_txn($sformatf("vec%0d", v), vecs[v].exp_g, vecs[v].exp_g, vecs[v].exp_srd,
             vecs[v].exp_swe, vecs[v].addr, vecs[v].wdata, vecs[v].waits, vecs[v].srdata,
             vecs[v].exp_rdata, 2'b11);
    end

    // Slave never ready: read strobe held 16 cycles, then ready+err with zero data.
    m_addr  = {32'h0000_4000, 32'h0};
    m_rd    = 2'b10;
    m_we    = 8'h00;
    s_rdata = 32'h7777_7777;
    step();
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("timeout.cyc%0d.s_rd_r", c), 64'(s_rd_r), 64'd1);
      chk($sformatf("timeout.cyc%0d.m_ready_r", c), 64'(m_ready_r), 64'd0);
      step();
    end
    chk("timeout.m_ready_r", 64'(m_ready_r), 64'(2'b10));
    chk("timeout.m_err_r", 64'(m_err_r), 64'(2'b10));
    chk("timeout.m_err_f", 64'(m_err_f), 64'(2'b10));
    chk("timeout.m_rdata_r", 64'(m_rdata_r), 64'd0);
    chk("timeout.s_rd_r", 64'(s_rd_r), 64'd0);
    m_rd = 2'b00;
    step();
    chk("timeout.after.m_err_r", 64'(m_err_r), 64'd0);
    chk("timeout.after.busy_r", 64'(busy_r), 64'd0);

    // Ready arriving on the last allowed cycle wins over the timeout.
    m_addr = {32'h0, 32'h0000_5000};
    m_rd   = 2'b01;
    step();
    for (int c = 0; c < 15; c++) step();
    chk("edge.busy_r", 64'(busy_r), 64'd1);
    chk("edge.m_ready_r", 64'(m_ready_r), 64'd0);
    s_rdata = 32'h1357_2468;
    s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    chk("edge.m_ready_r", 64'(m_ready_r), 64'(2'b01));
    chk("edge.m_err_r", 64'(m_err_r), 64'd0);
    chk("edge.m_rdata_r", 64'(m_rdata_r), 64'h1357_2468);
    m_rd = 2'b00;
    step();

    // Asynchronous reset in the middle of a write clears everything without a clock edge.
    m_addr = {32'h0, 32'h0000_6000};
    m_we   = 8'h03;
    step();
    chk("abort.busy_r", 64'(busy_r), 64'd1);
    #2;
    RSTN = 1'b0;
    #1;
    chk("abort.busy_r_low", 64'(busy_r), 64'd0);
    chk("abort.grant_r", 64'(grant_r), 64'd0);
    chk("abort.s_we_r", 64'(s_we_r), 64'd0);
    chk("abort.s_addr_r", 64'(s_addr_r), 64'd0);
    chk("abort.m_rdata_r", 64'(m_rdata_r), 64'd0);
    chk("abort.m_ready_r", 64'(m_ready_r), 64'd0);
    m_we    = 8'h00;
    m_rd    = 2'b11;
    m_addr  = {32'h0000_7100, 32'h0000_7000};
    m_wdata = {32'hB1B1_B1B1, 32'hB0B0_B0B0};
    @(negedge clk);
    RSTN = 1'b1;

    // Continuous requests from both: round robin alternates, fixed always picks master 0.
    for (int k = 0; k < 4; k++) begin
      do_txn($sformatf("rr%0d", k), 2'b01, (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 4'h0,
             (k % 2 == 0) ? 32'h0000_7000 : 32'h0000_7100,
             (k % 2 == 0) ? 32'hB0B0_B0B0 : 32'hB1B1_B1B1, 0,
             32'hA000_0000 + 32'(k), 32'hA000_0000 + 32'(k), 2'b00);
    end
    m_rd = 2'b00;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
